// File: rtl/audio_mixer_pkg.sv
// Shared helpers for the polyphonic sample mixer: silence level and mix accumulator width.
package audio_mixer_pkg;

    function automatic int unsigned silence_level(input int unsigned data_bits);
        return 32'd1 << (data_bits - 1);
    endfunction

    // Sum of num_voices full-scale unsigned samples never overflows this width.
    function automatic int unsigned acc_width(input int unsigned data_bits,
                                              input int unsigned num_voices);
        return data_bits + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/delta_sigma_dac.sv
// First-order 1-bit delta-sigma modulator; the output bit is the registered accumulator carry.
module delta_sigma_dac #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_level,
    output logic                 o_out
);
    logic [DATA_BITS-1:0] r_acc;
    logic                 r_out;
    logic [DATA_BITS:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_level};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= '0;
            r_out <= 1'b0;
        end else begin
            r_acc <= w_sum[DATA_BITS-1:0];
            r_out <= w_sum[DATA_BITS];
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/audio_voice_mixer.sv
// Polyphonic sample player: voices are swept once per output sample, mixed, and sent to a 1-bit DAC.
// Define AUDIO_MIXER_LOOP_EN to add the i_trig_loop port and looping voices.
module audio_voice_mixer
    import audio_mixer_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_BITS  = 14,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_DIV    = 5000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_trigger,
    input  logic [ADDR_BITS-1:0]  i_trig_start,
    input  logic [ADDR_BITS-1:0]  i_trig_len,
`ifdef AUDIO_MIXER_LOOP_EN
    input  logic                  i_trig_loop,
`endif
    output logic [ADDR_BITS-1:0]  o_rom_addr,
    input  logic [DATA_BITS-1:0]  i_rom_data,
    output logic [NUM_VOICES-1:0] o_voice_active,
    output logic                  o_audio
);
    localparam int unsigned ACC_W  = acc_width(DATA_BITS, NUM_VOICES);
    localparam int unsigned VIDX_W = $clog2(NUM_VOICES);
    localparam int unsigned TICK_W = $clog2(CLK_DIV);

    localparam logic [TICK_W-1:0]    TICK_LAST   = TICK_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0]    TICK_SWEEP  = TICK_W'(NUM_VOICES);
    localparam logic [TICK_W-1:0]    TICK_COMMIT = TICK_W'(NUM_VOICES + 1);
    localparam logic [DATA_BITS-1:0] SILENCE     = DATA_BITS'(silence_level(DATA_BITS));
    localparam logic [ACC_W-1:0]     MIX_RESET   = ACC_W'(silence_level(DATA_BITS) * NUM_VOICES);

    typedef struct packed {
        logic                 active;
        logic [ADDR_BITS-1:0] start;
        logic [ADDR_BITS-1:0] len;
        logic [ADDR_BITS-1:0] pos;
`ifdef AUDIO_MIXER_LOOP_EN
        logic                 loop;
`endif
    } voice_t;

    voice_t               r_voice   [NUM_VOICES];
    voice_t               w_voice_d [NUM_VOICES];
    logic [TICK_W-1:0]    r_tick;
    logic [VIDX_W-1:0]    r_steal_ptr;
    logic [ADDR_BITS-1:0] r_addr_hold;
    logic                 r_slot_active;
    logic [ACC_W-1:0]     r_mix_acc;
    logic [ACC_W-1:0]     r_mix;

    logic                 w_trig_ok;
    logic                 w_any_idle;
    logic [VIDX_W-1:0]    w_alloc_idx;
    logic                 w_in_sweep;
    logic [VIDX_W-1:0]    w_slot;
    logic [ADDR_BITS-1:0] w_sweep_addr;

    assign w_trig_ok    = i_trigger && (i_trig_len != '0);
    assign w_in_sweep   = (r_tick < TICK_SWEEP);
    assign w_slot       = r_tick[VIDX_W-1:0];
    assign w_sweep_addr = r_voice[w_slot].start + r_voice[w_slot].pos;
    assign o_rom_addr   = w_in_sweep ? w_sweep_addr : r_addr_hold;

    // Descending scan so the lowest-index idle voice wins; steal pointer if all busy.
    always_comb begin
        w_alloc_idx = r_steal_ptr;
        w_any_idle  = 1'b0;
        for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
            if (!r_voice[i].active) begin
                w_alloc_idx = VIDX_W'(i);
                w_any_idle  = 1'b1;
            end
        end
    end

    always_comb begin
        w_voice_d = r_voice;
        if (r_tick == TICK_COMMIT) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                if (r_voice[i].active) begin
                    if (r_voice[i].pos == r_voice[i].len - ADDR_BITS'(1)) begin
                        w_voice_d[i].pos = '0;
`ifdef AUDIO_MIXER_LOOP_EN
                        w_voice_d[i].active = r_voice[i].loop;
`else
                        w_voice_d[i].active = 1'b0;
`endif
                    end else begin
                        w_voice_d[i].pos = r_voice[i].pos + ADDR_BITS'(1);
                    end
                end
            end
        end
        // Applied after the advance so a same-cycle trigger takes precedence.
        if (w_trig_ok) begin
            w_voice_d[w_alloc_idx].active = 1'b1;
            w_voice_d[w_alloc_idx].start  = i_trig_start;
            w_voice_d[w_alloc_idx].len    = i_trig_len;
            w_voice_d[w_alloc_idx].pos    = '0;
`ifdef AUDIO_MIXER_LOOP_EN
            w_voice_d[w_alloc_idx].loop   = i_trig_loop;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_voice       <= '{default: '0};
            r_tick        <= '0;
            r_steal_ptr   <= '0;
            r_addr_hold   <= '0;
            r_slot_active <= 1'b0;
            r_mix_acc     <= '0;
            r_mix         <= MIX_RESET;
        end else begin
            r_voice <= w_voice_d;
            r_tick  <= (r_tick == TICK_LAST) ? '0 : r_tick + TICK_W'(1);
            // Active flag is captured with the address so a later trigger cannot relabel the data.
            if (w_in_sweep) begin
                r_addr_hold   <= w_sweep_addr;
                r_slot_active <= r_voice[w_slot].active;
            end
            if (r_tick == '0) begin
                r_mix_acc <= '0;
            end else if (r_tick <= TICK_SWEEP) begin
                r_mix_acc <= r_mix_acc + ACC_W'(r_slot_active ? i_rom_data : SILENCE);
            end
            if (r_tick == TICK_COMMIT) begin
                r_mix <= r_mix_acc;
            end
            if (w_trig_ok && !w_any_idle) begin
                r_steal_ptr <= (r_steal_ptr == VIDX_W'(NUM_VOICES - 1)) ? '0
                                                                          : r_steal_ptr + VIDX_W'(1);
            end
        end
    end

    always_comb begin
        o_voice_active = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            o_voice_active[i] = r_voice[i].active;
        end
    end

    delta_sigma_dac #(
        .DATA_BITS(DATA_BITS)
    ) u_dac (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_level(r_mix[ACC_W-1 -: DATA_BITS]),
        .o_out  (o_audio)
    );

endmodule
